seed_drop_sequencer: RTL and testbench

Controller that sequences the quadrature `encoder_counter` on the drive wheel. It clears the counter and homes on the index pulse, then loads a home offset. It then issues one seed-drop request per `spacing` encoder counts of forward travel, handshaking with the seed-metering actuator. It sits between the mission controller (start/abort, spacing, offset) and the `encoder_counter` instance, whose control inputs it owns exclusively.

---
 rtl/seed_drop_sequencer.sv | 179 +++++++++++++++++
 tb/tb_seed_drop_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seed_drop_sequencer.sv
// Sequencer for the drive-wheel encoder_counter: clear, home on index, load
// offset, then request one seed drop per `spacing` counts of forward travel.
module seed_drop_sequencer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int SPACING_WIDTH = 16,
  parameter int HOME_TIMEOUT  = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [SPACING_WIDTH-1:0] spacing,
  input  logic [COUNTER_WIDTH-1:0] home_offset,
  input  logic [COUNTER_WIDTH-1:0] position,
  input  logic                     direction,
  input  logic                     index_detected,
  input  logic [1:0]               enc_error_flags,
  input  logic                     drop_ack,
  output logic                     enc_enable,
  output logic                     enc_clear_count,
  output logic                     enc_set_count,
  output logic                     enc_clear_velocity,
  output logic [COUNTER_WIDTH-1:0] enc_count_value,
  output logic                     drop_req,
  output logic                     busy,
  output logic                     fault,
  output logic [2:0]               state,
  output logic [SPACING_WIDTH-1:0] seed_count,
  output logic [7:0]               missed_drops
);

  localparam int HT_W = (HOME_TIMEOUT > 2) ? $clog2(HOME_TIMEOUT) : 1;
  localparam logic [HT_W-1:0] HT_LAST = HT_W'(HOME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_HOMING = 3'd2,
    S_SET    = 3'd3,
    S_RUN    = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [SPACING_WIDTH-1:0] spacing_q, spacing_d;
  logic [COUNTER_WIDTH-1:0] offset_q, offset_d;
  logic [COUNTER_WIDTH-1:0] target_q, target_d;
  logic [HT_W-1:0]          home_cnt_q, home_cnt_d;
  logic                     drop_req_q, drop_req_d;
  logic [SPACING_WIDTH-1:0] seed_count_q, seed_count_d;
  logic [7:0]               missed_q, missed_d;
  logic                     enc_enable_q, enc_enable_d;
  logic                     enc_clear_q, enc_clear_d;
  logic                     enc_set_q, enc_set_d;
  logic [COUNTER_WIDTH-1:0] count_value_q, count_value_d;

  logic [COUNTER_WIDTH-1:0] pos_diff;
  logic                     hit;
  logic                     ack_take;
  logic                     enc_err;

  always_comb begin
    state_d       = state_q;
    spacing_d     = spacing_q;
    offset_d      = offset_q;
    target_d      = target_q;
    home_cnt_d    = home_cnt_q;
    drop_req_d    = drop_req_q;
    seed_count_d  = seed_count_q;
    missed_d      = missed_q;

    // Modular compare: position has reached target when the difference is non-negative
    pos_diff = position - target_q;
    hit      = direction & ~pos_diff[COUNTER_WIDTH-1];
    ack_take = drop_ack & drop_req_q;
    enc_err  = enc_error_flags[0];

    if (ack_take) drop_req_d = 1'b0;

    if (abort) begin
      state_d    = S_IDLE;
      drop_req_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (spacing != '0)) begin
            spacing_d    = spacing;
            offset_d     = home_offset;
            seed_count_d = '0;
            missed_d     = '0;
            drop_req_d   = 1'b0;
            state_d      = S_CLEAR;
          end
        end
        S_CLEAR: begin
          home_cnt_d = '0;
          state_d    = S_HOMING;
        end
        S_HOMING: begin
          if (enc_err)                  state_d = S_FAULT;
          else if (index_detected)      state_d = S_SET;
          else if (home_cnt_q == HT_LAST) state_d = S_FAULT;
          else                          home_cnt_d = home_cnt_q + 1'b1;
        end
        S_SET: begin
          target_d = offset_q + COUNTER_WIDTH'(spacing_q);
          state_d  = S_RUN;
        end
        S_RUN: begin
          if (enc_err) begin
            state_d = S_FAULT;
          end else if (hit) begin
            target_d = target_q + COUNTER_WIDTH'(spacing_q);
            // An ack in the same cycle frees the slot, so the hit becomes a fresh request
            if (!drop_req_q || ack_take) begin
              drop_req_d = 1'b1;
              if (seed_count_q != '1) seed_count_d = seed_count_q + 1'b1;
            end else if (missed_q != '1) begin
              missed_d = missed_q + 1'b1;
            end
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_FAULT) drop_req_d = 1'b0;

    enc_enable_d  = (state_d == S_HOMING) || (state_d == S_RUN);
    enc_clear_d   = (state_d == S_CLEAR);
    enc_set_d     = (state_d == S_SET);
    count_value_d = (state_d == S_SET) ? offset_q : count_value_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      spacing_q     <= '0;
      offset_q      <= '0;
      target_q      <= '0;
      home_cnt_q    <= '0;
      drop_req_q    <= 1'b0;
      seed_count_q  <= '0;
      missed_q      <= '0;
      enc_enable_q  <= 1'b0;
      enc_clear_q   <= 1'b0;
      enc_set_q     <= 1'b0;
      count_value_q <= '0;
    end else begin
      state_q       <= state_d;
      spacing_q     <= spacing_d;
      offset_q      <= offset_d;
      target_q      <= target_d;
      home_cnt_q    <= home_cnt_d;
      drop_req_q    <= drop_req_d;
      seed_count_q  <= seed_count_d;
      missed_q      <= missed_d;
      enc_enable_q  <= enc_enable_d;
      enc_clear_q   <= enc_clear_d;
      enc_set_q     <= enc_set_d;
      count_value_q <= count_value_d;
    end
  end

  assign enc_enable         = enc_enable_q;
  assign enc_clear_count    = enc_clear_q;
  assign enc_clear_velocity = enc_clear_q;
  assign enc_set_count      = enc_set_q;
  assign enc_count_value    = count_value_q;
  assign drop_req           = drop_req_q;
  assign seed_count         = seed_count_q;
  assign missed_drops       = missed_q;
  assign state              = state_q;
  assign busy               = (state_q == S_CLEAR) || (state_q == S_HOMING) ||
                              (state_q == S_SET)   || (state_q == S_RUN);
  assign fault              = (state_q == S_FAULT);

endmodule

// File: tb/tb_seed_drop_sequencer.sv
// Directed self-checking bench for seed_drop_sequencer.
module tb_seed_drop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] spacing;
  logic [31:0] home_offset, position;
  logic        direction, index_detected;
  logic [1:0]  enc_error_flags;
  logic        drop_ack;
  logic        enc_enable, enc_clear_count, enc_set_count, enc_clear_velocity;
  logic [31:0] enc_count_value;
  logic        drop_req, busy, fault;
  logic [2:0]  state;
  logic [15:0] seed_count;
  logic [7:0]  missed_drops;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  seed_drop_sequencer #(
    .COUNTER_WIDTH(32),
    .SPACING_WIDTH(16),
    .HOME_TIMEOUT (20)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .spacing           (spacing),
    .home_offset       (home_offset),
    .position          (position),
    .direction         (direction),
    .index_detected    (index_detected),
    .enc_error_flags   (enc_error_flags),
    .drop_ack          (drop_ack),
    .enc_enable        (enc_enable),
    .enc_clear_count   (enc_clear_count),
    .enc_set_count     (enc_set_count),
    .enc_clear_velocity(enc_clear_velocity),
    .enc_count_value   (enc_count_value),
    .drop_req          (drop_req),
    .busy              (busy),
    .fault             (fault),
    .state             (state),
    .seed_count        (seed_count),
    .missed_drops      (missed_drops)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, state, 0);
    check_eq({tag, "_en"}, enc_enable, 0);
    check_eq({tag, "_clr"}, enc_clear_count, 0);
    check_eq({tag, "_clrv"}, enc_clear_velocity, 0);
    check_eq({tag, "_set"}, enc_set_count, 0);
    check_eq({tag, "_val"}, enc_count_value, 0);
    check_eq({tag, "_req"}, drop_req, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_fault"}, fault, 0);
    check_eq({tag, "_seed"}, seed_count, 0);
    check_eq({tag, "_miss"}, missed_drops, 0);
  endtask

  // Drives a run from IDLE through CLEAR/HOMING/SET into RUN
  task automatic start_run(input logic [15:0] sp, input logic [31:0] off);
    spacing     = sp;
    home_offset = off;
    position    = off;
    direction   = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    check_eq("clear_state", state, 1);
    check_eq("clear_pulse", enc_clear_count, 1);
    check_eq("clear_vel", enc_clear_velocity, 1);
    check_eq("clear_busy", busy, 1);
    tick();
    check_eq("homing_state", state, 2);
    check_eq("homing_en", enc_enable, 1);
    check_eq("homing_clr", enc_clear_count, 0);
    index_detected = 1'b1;
    tick();
    index_detected = 1'b0;
    check_eq("set_state", state, 3);
    check_eq("set_pulse", enc_set_count, 1);
    check_eq("set_value", enc_count_value, {32'd0, off});
    tick();
    check_eq("run_state", state, 4);
    check_eq("run_setdone", enc_set_count, 0);
    check_eq("run_en", enc_enable, 1);
  endtask

  initial begin
    logic exp_req;
    rst_n = 1'b0; start = 0; abort = 0; spacing = 0; home_offset = 0; position = 0;
    direction = 0; index_detected = 0; enc_error_flags = 0; drop_ack = 0;
    tick(); tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // start with spacing 0 is ignored
    spacing = 0; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("zero_spacing_idle", state, 0);

    // Normal run: drops at 104, 108, 112; ack two cycles after each request
    start_run(16'd4, 32'd100);
    for (int p = 101; p <= 112; p++) begin
      position = p;
      drop_ack = (p == 106) || (p == 110);
      tick();
      exp_req = (p == 104) || (p == 105) || (p == 108) || (p == 109) || (p == 112);
      check_eq($sformatf("norm_req_%0d", p), drop_req, exp_req);
    end
    drop_ack = 1'b0;
    check_eq("norm_seed", seed_count, 3);
    check_eq("norm_miss", missed_drops, 0);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    rst_n = 1'b1;
    tick();

    // Wrap-around: target 2 after offset 0xFFFFFFFE, next target 6
    start_run(16'd4, 32'hFFFF_FFFE);
    position = 32'hFFFF_FFFF; tick(); check_eq("wrap_ff", drop_req, 0);
    position = 32'd0;         tick(); check_eq("wrap_0", drop_req, 0);
    position = 32'd1;         tick(); check_eq("wrap_1", drop_req, 0);
    position = 32'd2;         tick(); check_eq("wrap_2", drop_req, 1);
    check_eq("wrap_seed", seed_count, 1);
    position = 32'd5;         tick(); check_eq("wrap_5_miss", missed_drops, 0);
    position = 32'd6;         tick(); check_eq("wrap_6_miss", missed_drops, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_state", state, 0);
    check_eq("abort_req", drop_req, 0);
    check_eq("abort_en", enc_enable, 0);
    check_eq("abort_seed_held", seed_count, 1);
    check_eq("abort_miss_held", missed_drops, 1);

    // Missed drops with spacing 2, then ack+hit together, direction gating
    start_run(16'd2, 32'd0);
    for (int p = 1; p <= 6; p++) begin
      position = p;
      tick();
    end
    check_eq("miss_req", drop_req, 1);
    check_eq("miss_seed", seed_count, 1);
    check_eq("miss_cnt", missed_drops, 2);
    position = 32'd8; drop_ack = 1'b1; tick(); drop_ack = 1'b0;
    check_eq("ackhit_req", drop_req, 1);
    check_eq("ackhit_seed", seed_count, 2);
    check_eq("ackhit_miss", missed_drops, 2);
    position = 32'd9; drop_ack = 1'b1; tick();
    check_eq("ack_clear", drop_req, 0);
    tick(); drop_ack = 1'b0;
    check_eq("ack_idle_ignored", drop_req, 0);
    position = 32'd10; direction = 1'b0; tick();
    check_eq("rev_no_hit", seed_count, 2);
    direction = 1'b1; tick();
    check_eq("fwd_hit", seed_count, 3);
    abort = 1'b1; tick(); abort = 1'b0;

    // Homing timeout: fault exactly 20 cycles after HOMING entry
    spacing = 16'd1; start = 1'b1; tick(); start = 1'b0;
    tick();
    check_eq("to_homing", state, 2);
    for (int i = 0; i < 19; i++) tick();
    check_eq("to_still_homing", state, 2);
    tick();
    check_eq("to_fault_state", state, 5);
    check_eq("to_fault_flag", fault, 1);
    check_eq("to_fault_en", enc_enable, 0);
    check_eq("to_fault_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("fault_start_ignored", state, 5);
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("fault_abort", state, 0);

    // Error beats hit
    start_run(16'd4, 32'd0);
    position = 32'd4; enc_error_flags = 2'b01; tick(); enc_error_flags = 2'b00;
    check_eq("err_state", state, 5);
    check_eq("err_req", drop_req, 0);
    check_eq("err_seed", seed_count, 0);
    check_eq("err_en", enc_enable, 0);
    abort = 1'b1; tick(); abort = 1'b0;

    // Abort beats error and hit
    start_run(16'd4, 32'd0);
    position = 32'd4; enc_error_flags = 2'b01; abort = 1'b1; tick();
    enc_error_flags = 2'b00; abort = 1'b0;
    check_eq("aborterr_state", state, 0);
    check_eq("aborterr_req", drop_req, 0);
    check_eq("aborterr_seed", seed_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
